// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR register write controller.
package tmr_pkg;

  // Width of the retry counter; limits the number of rewrites to 15.
  localparam int RETRY_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2
  } tmr_wr_state_t;

endpackage

// File: rtl/tmr_write_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones, never wraps.
module sat_counter #(
  parameter int p_width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [p_width-1:0] count
);

  logic [p_width-1:0] count_q;
  logic [p_width-1:0] count_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {p_width{1'b1}})) begin
      count_d = count_q + p_width'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tmr_write_ctrl.sv
// Write-side controller for a triple-redundant voted register.
// Takes one word over valid/ready, writes it to all three channels with a
// single WE pulse, then checks the voted readback and voter error flag.
// Failed verifies trigger rewrites up to p_maxRetry times before reporting
// fail; a clean verify reports done. Both reports are one-cycle pulses.
// Optional feature: define TMR_WRITE_CTRL_ERRCNT_EN to build the saturating
// correctable-error counter behind errCnt; otherwise errCnt is tied to 0.
module tmr_write_ctrl
  import tmr_pkg::*;
#(
  parameter int p_dataSize = 8,
  parameter int p_maxRetry = 3,
  parameter int p_cntWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [p_dataSize-1:0] in_data,
  output logic                  WE,
  output logic [p_dataSize-1:0] outData_1,
  output logic [p_dataSize-1:0] outData_2,
  output logic [p_dataSize-1:0] outData_3,
  input  logic [p_dataSize-1:0] rdData,
  input  logic                  rdCorrectable,
  output logic                  done,
  output logic                  fail,
  output logic [RETRY_W-1:0]    retryCount,
  output logic [p_cntWidth-1:0] errCnt
);

  localparam logic [RETRY_W-1:0] MAX_RETRY = RETRY_W'(p_maxRetry);

  tmr_wr_state_t         state_q, state_d;
  logic [p_dataSize-1:0] hold_q, hold_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  we_q, we_d;
  logic                  in_ready_q, in_ready_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic                  verify_pass;

  assign verify_pass = (rdData == hold_q) && !rdCorrectable;

  // Next-state and next-output logic; all outputs are registered so they
  // line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    hold_d     = hold_q;
    retry_d    = retry_q;
    we_d       = 1'b0;
    in_ready_d = 1'b0;
    done_d     = 1'b0;
    fail_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          hold_d  = in_data;
          retry_d = '0;
          we_d    = 1'b1;
          state_d = WRITE;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      WRITE: begin
        state_d = VERIFY;
      end

      VERIFY: begin
        if (verify_pass) begin
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else if (retry_q < MAX_RETRY) begin
          retry_d = retry_q + RETRY_W'(1);
          we_d    = 1'b1;
          state_d = WRITE;
        end else begin
          fail_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM state, held word and registered outputs; reset returns to IDLE
  // immediately and drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      retry_q    <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      hold_q     <= hold_d;
      retry_q    <= retry_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign WE         = we_q;
  assign outData_1  = hold_q;
  assign outData_2  = hold_q;
  assign outData_3  = hold_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign retryCount = retry_q;

`ifdef TMR_WRITE_CTRL_ERRCNT_EN
  logic cnt_inc;

  // Count every verify cycle in which the voter reported a disagreement.
  assign cnt_inc = (state_q == VERIFY) && rdCorrectable;

  sat_counter #(
    .p_width(p_cntWidth)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .count(errCnt)
  );
`else
  assign errCnt = '0;
`endif

endmodule

// File: tb/tb_tmr_write_ctrl.sv
// Directed bench for tmr_write_ctrl with a behavioural TMR register model.
// Honours TMR_WRITE_CTRL_ERRCNT_EN for the expected errCnt values.
`timescale 1ns/1ps
module tb_tmr_write_ctrl;

`ifdef TMR_WRITE_CTRL_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       we;
  logic [7:0] out_d1, out_d2, out_d3;
  logic [7:0] rd_data;
  logic       rd_corr;
  logic       done, fail;
  logic [3:0] retry_count;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  tmr_write_ctrl #(
    .p_dataSize(8),
    .p_maxRetry(3),
    .p_cntWidth(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .WE           (we),
    .outData_1    (out_d1),
    .outData_2    (out_d2),
    .outData_3    (out_d3),
    .rdData       (rd_data),
    .rdCorrectable(rd_corr),
    .done         (done),
    .fail         (fail),
    .retryCount   (retry_count),
    .errCnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // TMR register model with fault injection knobs.
  logic [7:0] r1 = '0, r2 = '0, r3 = '0;
  logic [7:0] voted;
  bit         force_rd_zero = 1'b0;
  bit         force_corr    = 1'b0;
  int         stuck_target  = -1;
  int         we_cnt   = 0;
  int         done_cnt = 0;
  int         fail_cnt = 0;

  assign voted   = (r1 & r2) | (r1 & r3) | (r2 & r3);
  assign rd_data = force_rd_zero ? 8'h00 : voted;
  assign rd_corr = force_corr || (r1 != r2) || (r1 != r3);

  always @(posedge clk) begin
    if (we) begin
      r1 <= out_d1;
      r2 <= (we_cnt == stuck_target) ? 8'h00 : out_d2;
      r3 <= out_d3;
    end else begin
      r1 <= voted;
      r2 <= voted;
      r3 <= voted;
    end
  end

  always @(negedge clk) begin
    if (we)   we_cnt   <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (fail) fail_cnt <= fail_cnt + 1;
  end

  // Start a word and wait (bounded) for done or fail; cycles counts the
  // negedges from WRITE (1) to the pulse cycle.
  task automatic send_and_wait(input logic [7:0] d, output int cycles,
                               output bit got_done, output bit got_fail);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (!(done || fail) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    got_done = done;
    got_fail = fail;
    checks++;
    if (done && fail) begin
      errors++;
      $display("FAIL pulse_exclusive: done=%0b fail=%0b, required not both", done, fail);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", we); end
    checks++; if ({out_d1, out_d2, out_d3} !== 24'h0) begin errors++; $display("FAIL rst_out: got %h exp 0", {out_d1, out_d2, out_d3}); end
    checks++; if ({done, fail} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b exp 00", {done, fail}); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL rst_retry: got %0d exp 0", retry_count); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL rst_errcnt: got %0d exp 0", err_cnt); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int we0;
    we0 = we_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);                      // WRITE cycle (N+1)
    in_valid = 1'b0;
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL single_we_write: got %b exp 1", we); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_write: got %b exp 0", in_ready); end
    checks++; if ({out_d1, out_d2, out_d3} !== 24'hA5A5A5) begin errors++; $display("FAIL single_out: got %h exp a5a5a5", {out_d1, out_d2, out_d3}); end
    @(negedge clk);                      // VERIFY cycle (N+2)
    checks++; if ({we, done, fail} !== 3'b000) begin errors++; $display("FAIL single_verify: got we/done/fail %b exp 000", {we, done, fail}); end
    @(negedge clk);                      // done cycle (N+3)
    checks++; if ({done, fail} !== 2'b10) begin errors++; $display("FAIL single_done: got done/fail %b exp 10", {done, fail}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_idle: got %b exp 1", in_ready); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL single_retry: got %0d exp 0", retry_count); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b exp 0", done); end
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL single_we_pulses: got %0d exp 1", we_cnt - we0); end
  endtask

  task automatic test_retry();
    int cyc, we0, d0;
    bit gd, gf;
    we0 = we_cnt; d0 = done_cnt;
    stuck_target = we_cnt + 1;
    send_and_wait(8'h5A, cyc, gd, gf);
    stuck_target = -1;
    checks++; if ({gd, gf} !== 2'b10) begin errors++; $display("FAIL retry_result: got done/fail %b exp 10", {gd, gf}); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL retry_latency: got %0d exp 5", cyc); end
    checks++; if (retry_count !== 4'd1) begin errors++; $display("FAIL retry_count: got %0d exp 1", retry_count); end
    checks++; if (err_cnt !== (ERR_EN ? 2'd1 : 2'd0)) begin errors++; $display("FAIL retry_errcnt: got %0d exp %0d", err_cnt, ERR_EN ? 1 : 0); end
    @(negedge clk);
    checks++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL retry_we_pulses: got %0d exp 2", we_cnt - we0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL retry_done_count: got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_exhaust();
    int cyc, we0, d0, f0;
    bit gd, gf;
    we0 = we_cnt; d0 = done_cnt; f0 = fail_cnt;
    force_rd_zero = 1'b1;
    send_and_wait(8'h3C, cyc, gd, gf);
    force_rd_zero = 1'b0;
    checks++; if ({gd, gf} !== 2'b01) begin errors++; $display("FAIL exhaust_result: got done/fail %b exp 01", {gd, gf}); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL exhaust_latency: got %0d exp 9", cyc); end
    checks++; if (retry_count !== 4'd3) begin errors++; $display("FAIL exhaust_retry: got %0d exp 3", retry_count); end
    @(negedge clk);
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL exhaust_fail_width: got %b exp 0", fail); end
    checks++; if (we_cnt - we0 !== 4) begin errors++; $display("FAIL exhaust_we_pulses: got %0d exp 4", we_cnt - we0); end
    checks++; if (done_cnt - d0 !== 0 || fail_cnt - f0 !== 1) begin errors++; $display("FAIL exhaust_pulse_counts: got done %0d fail %0d exp 0 1", done_cnt - d0, fail_cnt - f0); end
    checks++; if (retry_count !== 4'd3) begin errors++; $display("FAIL exhaust_retry_hold: got %0d exp 3", retry_count); end
  endtask

  task automatic test_reset_mid();
    int cyc, d0, f0;
    bit gd, gf;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);                      // WRITE
    in_valid = 1'b0;
    @(negedge clk);                      // VERIFY
    d0 = done_cnt; f0 = fail_cnt;
    rst = 1'b1;
    #1;
    checks++; if ({in_ready, we, done, fail} !== 4'b1000) begin errors++; $display("FAIL midrst_ctrl: got ready/we/done/fail %b exp 1000", {in_ready, we, done, fail}); end
    checks++; if ({out_d1, out_d2, out_d3} !== 24'h0) begin errors++; $display("FAIL midrst_out: got %h exp 0", {out_d1, out_d2, out_d3}); end
    checks++; if (retry_count !== 4'd0 || err_cnt !== 2'd0) begin errors++; $display("FAIL midrst_counts: got retry %0d err %0d exp 0 0", retry_count, err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0 || fail_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_no_pulse: got done %0d fail %0d exp 0 0", done_cnt - d0, fail_cnt - f0); end
    send_and_wait(8'h22, cyc, gd, gf);
    checks++; if ({gd, gf} !== 2'b10 || cyc !== 3) begin errors++; $display("FAIL midrst_next_write: got done/fail %b cycles %0d exp 10 3", {gd, gf}, cyc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int         seen_at [3];
    int         k, cyc;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    k = 0; cyc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = words[0];
    while (k < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (we) begin
        checks++;
        if (out_d1 !== words[k]) begin errors++; $display("FAIL b2b_order_%0d: got %h exp %h", k, out_d1, words[k]); end
        seen_at[k] = cyc;
        k++;
        if (k < 3) in_data = words[k];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d exp 3", k); end
    if (k == 3) begin
      checks++; if (seen_at[1] - seen_at[0] !== 3 || seen_at[2] - seen_at[1] !== 3) begin errors++; $display("FAIL b2b_interval: got %0d %0d exp 3 3", seen_at[1] - seen_at[0], seen_at[2] - seen_at[1]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_errcnt_sat();
    int cyc;
    bit gd, gf;
    force_corr = 1'b1;
    send_and_wait(8'h77, cyc, gd, gf);     // four verifies, all flagged
    checks++; if (gf !== 1'b1 || err_cnt !== (ERR_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL errcnt_sat: got fail %b err %0d exp 1 %0d", gf, err_cnt, ERR_EN ? 3 : 0); end
    send_and_wait(8'h78, cyc, gd, gf);     // four more: must not wrap
    force_corr = 1'b0;
    checks++; if (err_cnt !== (ERR_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL errcnt_nowrap: got %0d exp %0d", err_cnt, ERR_EN ? 3 : 0); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_retry();
    test_exhaust();
    test_reset_mid();
    test_back_to_back();
    test_errcnt_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
